// File: rtl/div_unit.sv
// div_unit: iterative 32-bit DIV/DIVU for the EXE stage (radix-2 restoring).
// Ports: clk, rst (async, active-low), start/sign/dividend/divisor/flush
// in; busy (stall), done (1-cycle pulse), quotient (LO), remainder (HI) out.
// Build option: DIV_FAST_ZERO_EN skips RUN when the divisor is zero.
module div_unit #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sign,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder
);

  localparam int W  = DIV_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] cnt;
  logic [W-1:0]  a_raw;
  logic [W-1:0]  b_mag;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic          neg_q;
  logic          neg_r;
  logic          div_zero;

  logic          accept;
  logic          zero_in;
  logic          ld_run;
  logic          ld_fast;
  logic [W-1:0]  a_abs;
  logic [W-1:0]  b_abs;
  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          ge;
  logic [W-1:0]  rem_nxt;
  logic [W-1:0]  quo_nxt;
  logic [W-1:0]  q_res;
  logic [W-1:0]  r_res;

  assign accept  = (state == IDLE) && start && !flush;
  assign zero_in = (divisor == '0);

  assign a_abs = (sign && dividend[W-1]) ? -dividend : dividend;
  assign b_abs = (sign && divisor[W-1])  ? -divisor  : divisor;

  // quo starts as the dividend magnitude and is shifted out MSB-first
  // into the partial remainder while quotient bits shift in at the LSB.
  // The partial remainder stays below b_mag, so diff[W] is a clean borrow.
  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, b_mag};
  assign ge      = !diff[W];
  assign rem_nxt = ge ? diff[W-1:0] : shifted[W-1:0];
  assign quo_nxt = {quo[W-2:0], ge};

  always_comb begin
    q_res = neg_q ? -quo_nxt : quo_nxt;
    r_res = neg_r ? -rem_nxt : rem_nxt;
    if (div_zero) begin
      q_res = '1;
      r_res = a_raw;
    end
  end

  assign ld_run = (state == RUN) && !flush && (cnt == LAST);

`ifdef DIV_FAST_ZERO_EN
  assign ld_fast = accept && zero_in;
`else
  assign ld_fast = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = start && !flush;
        if (start && !flush) begin
          state_nxt = ld_fast ? FINISH : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        done      = !flush;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      a_raw    <= '0;
      b_mag    <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      a_raw    <= dividend;
      b_mag    <= b_abs;
      rem      <= '0;
      quo      <= a_abs;
      neg_q    <= sign && (dividend[W-1] ^ divisor[W-1]);
      neg_r    <= sign && dividend[W-1];
      div_zero <= zero_in;
    end else if (state == RUN && !flush) begin
      cnt <= cnt + 1'b1;
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (ld_fast) begin
      quotient  <= '1;
      remainder <= dividend;
    end else if (ld_run) begin
      quotient  <= q_res;
      remainder <= r_res;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed stimulus with a queue scoreboard for div_unit.
// A negedge monitor pops expected results whenever done is seen.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          ec;
  } exp_t;

  exp_t        sb[$];
  int          ec;
  int          n_chk;
  int          n_pass;
  int          n_done;
  int          n_exp;
  logic [31:0] last_q;
  logic [31:0] last_r;

  div_unit #(.DIV_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sign(sign),
    .dividend(dividend),
    .divisor(divisor),
    .flush(flush),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ec = 0;
  always @(posedge clk) ec <= ec + 1;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 at edge %0d want none", ec);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("latency_edge", ec, e.ec);
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq,
                       input logic [31:0] er, input bit push);
    exp_t e;
    int   lat;
    lat = 33;
`ifdef DIV_FAST_ZERO_EN
    if (b == 32'h0) lat = 1;
`endif
    @(posedge clk);
    #1;
    start    = 1'b1;
    sign     = s;
    dividend = a;
    divisor  = b;
    #1;
    check("busy_on_start", {31'b0, busy}, 32'd1);
    if (push) begin
      e.q = eq;
      e.r = er;
      e.ec = ec + lat;
      sb.push_back(e);
      n_exp++;
      last_q = eq;
      last_r = er;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL done_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er);
    issue(s, a, b, eq, er, 1'b1);
    wait_sb();
  endtask

  initial begin
    bit busy_ok;
    n_chk    = 0;
    n_pass   = 0;
    n_done   = 0;
    n_exp    = 0;
    last_q   = '0;
    last_r   = '0;
    rst      = 1'b0;
    start    = 1'b0;
    sign     = 1'b0;
    dividend = '0;
    divisor  = '0;
    flush    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient", quotient, 32'h0);
    check("rst_remainder", remainder, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;

    // DIVU 100/7 with busy profile across the whole RUN
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    busy_ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("busy_run", {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    check("busy_finish", {31'b0, busy}, 32'd0);
    wait_sb();

    run_vec(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_vec(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
    run_vec(1'b0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678);
    run_vec(1'b1, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9);
    run_vec(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_vec(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE);
    run_vec(1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1);
    run_vec(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0);
    run_vec(1'b0, 32'd5, 32'd10, 32'd0, 32'd5);

    // start together with flush in IDLE is dropped
    @(posedge clk);
    #1;
    start    = 1'b1;
    flush    = 1'b1;
    dividend = 32'd8;
    divisor  = 32'd2;
    #1;
    check("busy_start_flush", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    #1;
    check("idle_after_flush_start", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // flush at RUN cycle 10
    issue(1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_hold_q", quotient, last_q);
    check("flush_hold_r", remainder, last_r);
    repeat (40) @(negedge clk);
    run_vec(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // start held through RUN and FINISH with changed operands
    @(posedge clk);
    #1;
    start    = 1'b1;
    sign     = 1'b0;
    dividend = 32'd20;
    divisor  = 32'd4;
    begin
      exp_t e;
      e.q = 32'd5;
      e.r = 32'd0;
      e.ec = ec + 33;
      sb.push_back(e);
      n_exp++;
    end
    @(posedge clk);
    #1;
    dividend = 32'd99;
    divisor  = 32'd2;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check("busy_finish_start", {31'b0, busy}, 32'd0);
    start = 1'b0;
    repeat (40) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL held_start_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end

    // reset at RUN cycle 20
    issue(1'b0, 32'd77, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_quotient", quotient, 32'h0);
    check("midrst_remainder", remainder, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(negedge clk);
    run_vec(1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

    repeat (5) @(negedge clk);
    check("done_count", n_done, n_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  EXE-stage request for DIV/DIVU (ID_EXE ALUOp decode).
REQ-005 SHALL have port sign  input  1  1 = DIV (signed), 0 = DIVU.
REQ-006 SHALL have port dividend  input  32  forwarded EXE BusA value.
REQ-007 SHALL have port divisor  input  32  forwarded EXE BusB value.
REQ-008 SHALL have port flush  input  1  EXE-stage flush (exception/ERET); cancels the operation.
REQ-009 SHALL have port busy  output  1  stall request to PC/IF_ID/ID_EXE write enables.
REQ-010 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-011 SHALL have port quotient  output  32  LO write data.
REQ-012 SHALL have port remainder  output  32  HI write data.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FINISH.
REQ-014 IDLE: start=1 and flush=0 SHALL latch sign, dividend, divisor and enter RUN with the iteration counter at 0; start with flush=1 SHALL be ignored.
REQ-015 RUN SHALL perform one radix-2 restoring iteration per cycle on operand magnitudes; after exactly 32 RUN cycles, enter FINISH.
REQ-016 FINISH SHALL assert done for exactly one cycle, then return to IDLE unconditionally; a start in FINISH SHALL be ignored.
REQ-017 Latency: start sampled at edge 0 SHALL give done=1 in the cycle after edge 33.
REQ-018 busy SHALL be combinational: 1 in RUN, and 1 in IDLE while start=1 and flush=0; 0 in FINISH and otherwise.
REQ-019 start while in RUN SHALL be ignored; the latched operands SHALL NOT change until the next accepted start.
REQ-020 Signed: quotient SHALL be negative iff operand signs differ, and the remainder SHALL take the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0.
REQ-021 Divisor 0 (either sign mode) SHALL give quotient 0xFFFFFFFF and remainder equal to the raw dividend.
REQ-022 quotient/remainder SHALL be registered, updated only on entry to FINISH, and held until the next FINISH.
REQ-023 flush=1 in RUN or FINISH SHALL force IDLE at the next edge: no done, outputs keep their previous values.

Reset
REQ-024 rst=0 SHALL immediately force IDLE, counter 0, done 0, quotient 0, remainder 0; busy then follows REQ-018.
REQ-025 Reset asserted mid-RUN SHALL abort silently; the first start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro DIV_FAST_ZERO_EN defined: a start with divisor 0 SHALL go IDLE->FINISH directly, so done comes in the cycle after edge 1 with the REQ-021 values.
REQ-027 Macro DIV_FAST_ZERO_EN undefined: divisor 0 SHALL take the full 32-cycle RUN path with identical result values.

Verification
REQ-028 DIVU 100/7: start at edge 0 -> done in cycle after edge 33, quotient 14, remainder 2; busy high in cycles 0..32.
REQ-029 DIV 0xFFFFFFF9(-7)/2 -> quotient 0xFFFFFFFD(-3), remainder 0xFFFFFFFF(-1); DIV 0x80000000/0xFFFFFFFF -> 0x80000000, 0.
REQ-030 DIVU 0x12345678/0 -> quotient 0xFFFFFFFF, remainder 0x12345678; done after 1 cycle with DIV_FAST_ZERO_EN, after 33 without.
REQ-031 flush at RUN cycle 10 -> IDLE next cycle, no done, prior quotient/remainder unchanged; a new DIVU 9/3 then gives 3, 0.
REQ-032 start held high through RUN and FINISH with other operands -> only first operation completes; exactly one done pulse.
REQ-033 rst low at RUN cycle 20 -> outputs 0 immediately, done never pulses; DIVU 50/5 after release -> 10, 0.
